// File: rtl/types.sv
// Shared DRAM geometry and arbiter state encoding for the PIM memory path.
package types;

  localparam int ADDRESS_LEN        = 32;
  localparam int BURST_ACCESS_WIDTH = 256;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Rotating through a doubled vector turns the wrap-around search into a plain scan.
  logic [2*N-1:0] req_rot;
  logic [PW:0]    pos;

  assign req_rot = {req, req} >> ptr;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && req_rot[k]) begin
        any = 1'b1;
        pos = {1'b0, ptr} + (PW + 1)'(k);
        if (pos >= (PW + 1)'(N)) pos = pos - (PW + 1)'(N);
        idx = pos[PW-1:0];
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one full-row DRAM port among NUM_REQ requesters.
// Optional statistics (grant_cnt, busy_cycles) are built when DRAM_ARB_STATS_EN is defined.
module dram_port_arbiter
  import types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDRESS_LEN,
  parameter int DATA_W  = BURST_ACCESS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
`ifdef DRAM_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]     grant_cnt,
  output logic [31:0]               busy_cycles,
`endif
  output logic [ADDR_W-1:0]         addr,
  output logic                      read_en,
  output logic                      write_en,
  output logic [DATA_W-1:0]         wdata,
  input  logic                      dram_ready,
  input  logic                      dram_complete,
  input  logic                      valid,
  input  logic [DATA_W-1:0]         rdata
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  logic [NUM_REQ-1:0] pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  arb_state_t         state_q,      state_d;
  logic [NUM_REQ-1:0] req_ready_q,  req_ready_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic               read_en_q,    read_en_d;
  logic               write_en_q,   write_en_d;
  logic               we_q,         we_d;
  logic [ADDR_W-1:0]  addr_q,       addr_d;
  logic [DATA_W-1:0]  wdata_q,      wdata_d;
  logic [DATA_W-1:0]  rdata_q,      rdata_d;
  logic [PTR_W-1:0]   rr_ptr_q,     rr_ptr_d;
  logic [PTR_W-1:0]   owner_q,      owner_d;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    read_en_d    = read_en_q;
    write_en_d   = write_en_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any && dram_ready) begin
          req_ready_d = pick_grant;
          owner_d     = pick_idx;
          addr_d      = addr_arr[pick_idx];
          wdata_d     = wdata_arr[pick_idx];
          we_d        = req_we[pick_idx];
          read_en_d   = !req_we[pick_idx];
          write_en_d  = req_we[pick_idx];
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A beat arriving with the completion pulse is still captured.
        if (valid && !we_q) rdata_d = rdata;
        if (dram_complete) begin
          read_en_d    = 1'b0;
          write_en_d   = 1'b0;
          resp_valid_d = NUM_REQ'(1) << owner_q;
          state_d      = ARB_RESP;
        end
      end
      ARB_RESP: begin
        rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      read_en_q    <= read_en_d;
      write_en_q   <= write_en_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign addr       = addr_q;
  assign read_en    = read_en_q;
  assign write_en   = write_en_q;
  assign wdata      = wdata_q;

`ifdef DRAM_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] grant_cnt_d [NUM_REQ];
  logic [31:0] busy_cycles_q, busy_cycles_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i] + (req_ready_q[i] ? 32'd1 : 32'd0);
    end
    busy_cycles_d = busy_cycles_q;
    if (state_q == ARB_BUSY && busy_cycles_q != '1) busy_cycles_d = busy_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      busy_cycles_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      busy_cycles_q <= busy_cycles_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    assign grant_cnt[g*32 +: 32] = grant_cnt_q[g];
  end
  assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: stimulus pushes expected grants, commands and
// responses; negedge monitors pop and compare whenever the DUT presents them.
module tb_dram_port_arbiter;
  import types::*;

  localparam int NR = 4;
  localparam int AW = ADDRESS_LEN;
  localparam int DW = BURST_ACCESS_WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready, req_we, resp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    resp_rdata, wdata, rdata;
  logic [AW-1:0]    addr;
  logic             read_en, write_en, dram_ready, dram_complete, valid;
`ifdef DRAM_ARB_STATS_EN
  logic [NR*32-1:0] grant_cnt;
  logic [31:0]      busy_cycles;
`endif

  logic [NR-1:0] hold;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
  } cmd_t;

  typedef struct {
    logic [NR-1:0] onehot;
    logic          chk;
    logic [DW-1:0] d;
  } resp_t;

  int    grant_q[$];
  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  dram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
`ifdef DRAM_ARB_STATS_EN
    .grant_cnt     (grant_cnt),
    .busy_cycles   (busy_cycles),
`endif
    .addr          (addr),
    .read_en       (read_en),
    .write_en      (write_en),
    .wdata         (wdata),
    .dram_ready    (dram_ready),
    .dram_complete (dram_complete),
    .valid         (valid),
    .rdata         (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: grants, command issue, responses.
  initial begin
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (req_ready != '0) begin
          if (grant_q.size() == 0) check("grant_unexpected", DW'(req_ready), '0);
          else check("grant_order", DW'(req_ready), DW'(NR'(1) << grant_q.pop_front()));
        end
        if ((read_en || write_en) && !prev_en) begin
          if (cmd_q.size() == 0) begin
            check("cmd_unexpected", DW'(read_en | write_en), '0);
          end else begin
            cmd_t c;
            c = cmd_q.pop_front();
            check("cmd_write_en", DW'(write_en), DW'(c.we));
            check("cmd_read_en", DW'(read_en), DW'(!c.we));
            check("cmd_addr", DW'(addr), DW'(c.a));
            if (c.we) check("cmd_wdata", wdata, c.w);
          end
        end
        prev_en = read_en || write_en;
        if (resp_valid != '0) begin
          if (resp_q.size() == 0) begin
            check("resp_unexpected", DW'(resp_valid), '0);
          end else begin
            resp_t r;
            r = resp_q.pop_front();
            check("resp_owner", DW'(resp_valid), DW'(r.onehot));
            if (r.chk) check("resp_rdata", resp_rdata, r.d);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (req_ready[i] && !hold[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int g, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w);
    req_addr[g*AW +: AW]  = a;
    req_wdata[g*DW +: DW] = w;
    req_we[g]             = we;
    req_valid[g]          = 1'b1;
  endtask

  task automatic expect_txn(input int g, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] w, input logic [DW-1:0] d);
    cmd_t  c;
    resp_t r;
    c.we = we; c.a = a; c.w = w;
    r.onehot = NR'(1) << g; r.chk = !we; r.d = d;
    grant_q.push_back(g);
    cmd_q.push_back(c);
    resp_q.push_back(r);
  endtask

  // Plays the DRAM side of one transaction once an enable appears.
  task automatic serve(input int exp_lat, input logic is_rd, input logic [DW-1:0] d,
                       input int nbeats, input bit same);
    int n;
    n = 0;
    while (!(read_en || write_en) && n < 20) begin
      tick();
      n++;
    end
    if (!(read_en || write_en)) begin
      check("issue_timeout", '0, DW'(1));
      return;
    end
    if (exp_lat > 0) check("issue_latency", DW'(n), DW'(exp_lat));
    begin
      logic [AW-1:0] a0;
      logic [DW-1:0] w0;
      a0 = addr;
      w0 = wdata;
      for (int k = 0; k < 2; k++) tick();
      check("en_held", DW'(read_en | write_en), DW'(1));
      check("addr_stable", DW'(addr), DW'(a0));
      check("wdata_stable", wdata, w0);
    end
    for (int b = 0; b < nbeats; b++) begin
      valid = 1'b1;
      rdata = (b == nbeats - 1) ? d : ~d;
      if (!is_rd) rdata = {DW/8{8'h5A}};
      if (same && b == nbeats - 1) dram_complete = 1'b1;
      tick();
    end
    valid = 1'b0;
    if (!same || nbeats == 0) begin
      dram_complete = 1'b1;
      tick();
    end
    dram_complete = 1'b0;
    check("en_drop", DW'(read_en | write_en), '0);
    check("resp_next_cycle", DW'(resp_valid != '0), DW'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    hold = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; hold = '0;
    dram_ready = 1'b0; dram_complete = 1'b0; valid = 1'b0; rdata = '0;

    // Reset values
    do_reset();
    rst = 1'b1;
    tick();
    check("rst_req_ready", DW'(req_ready), '0);
    check("rst_resp_valid", DW'(resp_valid), '0);
    check("rst_enables", DW'({read_en, write_en}), '0);
    check("rst_addr", DW'(addr), '0);
    check("rst_wdata", wdata, '0);
    check("rst_resp_rdata", resp_rdata, '0);
    rst = 1'b0;
    tick();

    // Single read, two beats (last one wins)
    d = {DW/8{8'hA5}};
    dram_ready = 1'b1;
    set_req(0, 1'b0, 32'h40, '0);
    expect_txn(0, 1'b0, 32'h40, '0, d);
    serve(1, 1'b1, d, 2, 1'b0);
    tick();

    // Single write; stray valid during the write is ignored
    set_req(2, 1'b1, 32'h80, DW'(16'h1234));
    expect_txn(2, 1'b1, 32'h80, DW'(16'h1234), '0);
    serve(1, 1'b0, '0, 1, 1'b0);
    tick();

    // All four requesting continuously from rr_ptr = 0
    do_reset();
    hold = 4'b1111;
    for (int g = 0; g < NR; g++) set_req(g, 1'b0, AW'(32'h100 * (g + 1)), '0);
    for (int t = 0; t < 5; t++) begin
      int g;
      g = t % NR;
      expect_txn(g, 1'b0, AW'(32'h100 * (g + 1)), '0, {DW/32{32'hD000_0000 | 32'(g)}});
    end
    for (int t = 0; t < 5; t++) serve(0, 1'b1, {DW/32{32'hD000_0000 | 32'(t % NR)}}, 1, 1'b0);
    req_valid = '0;
    hold = '0;
`ifdef DRAM_ARB_STATS_EN
    check("stat_grant0", DW'(grant_cnt[0*32 +: 32]), DW'(2));
    check("stat_grant1", DW'(grant_cnt[1*32 +: 32]), DW'(1));
    check("stat_grant2", DW'(grant_cnt[2*32 +: 32]), DW'(1));
    check("stat_grant3", DW'(grant_cnt[3*32 +: 32]), DW'(1));
    check("stat_busy", DW'(busy_cycles), DW'(20));
`endif
    tick();

    // Only req1 and req3 active: grants alternate 1,3,1
    hold = 4'b1010;
    set_req(1, 1'b0, 32'h200, '0);
    set_req(3, 1'b0, 32'h400, '0);
    expect_txn(1, 1'b0, 32'h200, '0, DW'(32'h11));
    expect_txn(3, 1'b0, 32'h400, '0, DW'(32'h33));
    expect_txn(1, 1'b0, 32'h200, '0, DW'(32'h12));
    serve(0, 1'b1, DW'(32'h11), 1, 1'b0);
    serve(0, 1'b1, DW'(32'h33), 1, 1'b0);
    serve(0, 1'b1, DW'(32'h12), 1, 1'b0);
    req_valid = '0;
    hold = '0;
    tick();

    // dram_ready low for 10 cycles with a request pending
    dram_ready = 1'b0;
    set_req(1, 1'b0, 32'h240, '0);
    for (int t = 0; t < 10; t++) begin
      tick();
      check("stall_no_ready", DW'(req_ready), '0);
      check("stall_no_en", DW'(read_en | write_en), '0);
    end
    expect_txn(1, 1'b0, 32'h240, '0, {DW/16{16'hBEEF}});
    dram_ready = 1'b1;
    serve(1, 1'b1, {DW/16{16'hBEEF}}, 1, 1'b0);
    tick();

    // Same-cycle valid + complete, then a stray complete in IDLE
    d = {DW/8{8'h3C}};
    set_req(1, 1'b0, 32'h280, '0);
    expect_txn(1, 1'b0, 32'h280, '0, d);
    serve(1, 1'b1, d, 1, 1'b1);
    tick();
    dram_complete = 1'b1;
    valid = 1'b1;
    rdata = {DW/8{8'hEE}};
    tick();
    dram_complete = 1'b0;
    valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("stray_no_resp", DW'(resp_valid), '0);
      check("stray_no_en", DW'(read_en | write_en), '0);
    end
    check("rdata_hold", resp_rdata, d);

    // Reset mid-BUSY; rr_ptr was 2, must return to 0
    begin
      cmd_t c;
      c.we = 1'b0; c.a = 32'h300; c.w = '0;
      set_req(2, 1'b0, 32'h300, '0);
      grant_q.push_back(2);
      cmd_q.push_back(c);
      for (int t = 0; t < 20 && !read_en; t++) tick();
      check("abort_issued", DW'(read_en), DW'(1));
      tick();
      rst = 1'b1;
      tick();
      check("abort_read_en", DW'(read_en), '0);
      check("abort_resp_valid", DW'(resp_valid), '0);
      check("abort_addr", DW'(addr), '0);
      rst = 1'b0;
      for (int t = 0; t < 3; t++) begin
        tick();
        check("abort_no_resp", DW'(resp_valid), '0);
      end
    end
    set_req(1, 1'b0, 32'h500, '0);
    set_req(3, 1'b0, 32'h600, '0);
    expect_txn(1, 1'b0, 32'h500, '0, DW'(32'h51));
    expect_txn(3, 1'b0, 32'h600, '0, DW'(32'h63));
    serve(1, 1'b1, DW'(32'h51), 1, 1'b0);
    serve(0, 1'b1, DW'(32'h63), 1, 1'b0);
    tick();
    tick();

    check("grant_q_empty", DW'(grant_q.size()), '0);
    check("cmd_q_empty", DW'(cmd_q.size()), '0);
    check("resp_q_empty", DW'(resp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
